pf_next_line_gen: RTL and testbench



---
 rtl/pf_next_line_gen_pkg.sv | 18 +
 rtl/pf_next_line_gen_if.sv | 34 +++
 rtl/pf_next_line_gen.sv | 120 ++++++++++++
 tb/tb_pf_next_line_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_next_line_gen_pkg.sv
// rtl/pf_next_line_gen_pkg.sv - shared icache prefetch types and address-geometry constants
package pf_next_line_gen_pkg;

  // Prefetch generator FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } pf_state_e;

  // Default 128-bit line and 4 KiB prefetch page
  localparam int unsigned PF_LINE_BYTES = 16;
  localparam int unsigned PF_PAGE_BYTES = 4096;

  // Byte-offset widths inside a line and inside a page
  localparam int unsigned PF_LINE_OFF_W = $clog2(PF_LINE_BYTES);
  localparam int unsigned PF_PAGE_OFF_W = $clog2(PF_PAGE_BYTES);

endpackage

// File: rtl/pf_next_line_gen_if.sv
// rtl/pf_next_line_gen_if.sv - miss input and prefetch request/grant channel bundle
interface pf_next_line_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 16
);

  logic                  miss_valid_i;
  logic [ADDR_WIDTH-1:0] miss_addr_i;
  logic                  pf_req_o;
  logic [ADDR_WIDTH-1:0] pf_add_o;
  logic [ID_WIDTH-1:0]   pf_ID_o;
  logic                  pf_gnt_i;

  // Generator side: consumes misses, issues prefetch requests
  modport master (
    input  miss_valid_i,
    input  miss_addr_i,
    input  pf_gnt_i,
    output pf_req_o,
    output pf_add_o,
    output pf_ID_o
  );

  // Cache/mux side: reports misses, grants prefetch requests
  modport slave (
    output miss_valid_i,
    output miss_addr_i,
    output pf_gnt_i,
    input  pf_req_o,
    input  pf_add_o,
    input  pf_ID_o
  );

endinterface

// File: rtl/pf_next_line_gen.sv
// rtl/pf_next_line_gen.sv - next-line instruction prefetch generator bounded by page and window filter
module pf_next_line_gen
  import pf_next_line_gen_pkg::*;
#(
  parameter int unsigned        ADDR_WIDTH = 32,
  parameter int unsigned        ID_WIDTH   = 16,
  parameter int unsigned        LINE_BYTES = PF_LINE_BYTES,
  parameter int unsigned        PAGE_BYTES = PF_PAGE_BYTES,
  parameter int unsigned        PF_DEPTH   = 2,
  parameter logic [ID_WIDTH-1:0] PF_ID     = {ID_WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  pf_next_line_gen_if.master   bus,
  output logic                 busy_o,
  output logic [15:0]          pf_cnt_o
);

  localparam int unsigned LOFF_W = $clog2(LINE_BYTES);
  localparam int unsigned POFF_W = $clog2(PAGE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(LINE_STEP - 1'b1);

  pf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [3:0]            rem_q, rem_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] miss_line, trig_line, trig_first, next_inc;
  logic [ADDR_WIDTH-1:0] win_off, win_span;
  logic                  trig_valid, grant, last_grant, in_window;

  function automatic logic same_page(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    return a[ADDR_WIDTH-1:POFF_W] == b[ADDR_WIDTH-1:POFF_W];
  endfunction

  // Trigger selection, grant bookkeeping and window membership of an incoming miss
  always_comb begin
    miss_line  = bus.miss_addr_i & LINE_MASK;
    trig_valid = bus.miss_valid_i | pend_valid_q;
    trig_line  = bus.miss_valid_i ? miss_line : pend_addr_q;
    trig_first = trig_line + LINE_STEP;
    next_inc   = next_q + LINE_STEP;
    grant      = (state_q == ISSUE) & bus.pf_gnt_i;
    last_grant = grant & ((rem_q == 4'd1) | ~same_page(next_q, next_inc) | ~enable_i);
    win_off    = miss_line - next_q;
    win_span   = ADDR_WIDTH'(rem_q) << LOFF_W;
    in_window  = win_off < win_span;
  end

  // Next-state logic: a newer miss takes priority over the pending entry when idle
  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    rem_d        = rem_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    if (grant && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        pend_valid_d = 1'b0;
        if (enable_i && trig_valid && same_page(trig_line, trig_first)) begin
          state_d = ISSUE;
          next_d  = trig_first;
          rem_d   = 4'(PF_DEPTH);
        end
      end
      ISSUE: begin
        if (grant) begin
          next_d = next_inc;
          rem_d  = rem_q - 4'd1;
          if (last_grant) begin
            state_d = IDLE;
          end
        end
        // The final grant closes the window, so a coincident miss is kept
        if (bus.miss_valid_i && (last_grant || !in_window)) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = miss_line;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      pend_valid_d = 1'b0;
    end
  end

  // State registers; reset aborts any burst without leaving a request up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      next_q       <= '0;
      rem_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      rem_q        <= rem_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.pf_req_o = (state_q == ISSUE);
  assign bus.pf_add_o = next_q;
  assign bus.pf_ID_o  = PF_ID;
  assign busy_o       = (state_q != IDLE) | pend_valid_q;
  assign pf_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pf_next_line_gen.sv
// tb/tb_pf_next_line_gen.sv - self-checking bench for the next-line prefetch generator
module tb_pf_next_line_gen;

  localparam int unsigned L  = 16;
  localparam int unsigned D  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [15:0] cnt;

  pf_next_line_gen_if #(.ADDR_WIDTH(32), .ID_WIDTH(16)) bus_if ();

  pf_next_line_gen #(
    .ADDR_WIDTH(32), .ID_WIDTH(16), .LINE_BYTES(L), .PAGE_BYTES(4096),
    .PF_DEPTH(D), .PF_ID(16'hFFFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .bus      (bus_if),
    .busy_o   (busy),
    .pf_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // Reference model state (burst-level view)
  bit          m_active;
  logic [31:0] m_cur;
  int          m_rem;
  bit          m_pend_v;
  logic [31:0] m_pend_a;
  int          m_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_miss(input logic [31:0] a);
    bus_if.miss_valid_i = 1'b1;
    bus_if.miss_addr_i  = a;
    step();
    bus_if.miss_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    bus_if.miss_valid_i = 1'b0; bus_if.miss_addr_i = '0; bus_if.pf_gnt_i = 1'b0;
    step();
    checks += 5;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h0) begin errors++; $display("FAIL reset_add: got %h exp 0", bus_if.pf_add_o); end
    if (bus_if.pf_ID_o !== 16'hFFFF) begin errors++; $display("FAIL reset_id: got %h exp ffff", bus_if.pf_ID_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    if (cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", cnt); end
    rst = 1'b0;
    step();
    exp_cnt = 0;
  endtask

  task automatic test_basic_burst();
    enable = 1'b1; bus_if.pf_gnt_i = 1'b1;
    pulse_miss(32'h1000_0104);
    checks += 2;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL basic_req1: got %0b exp 1", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h1000_0110) begin errors++; $display("FAIL basic_add1: got %h exp 10000110", bus_if.pf_add_o); end
    step();
    checks += 3;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL basic_req2: got %0b exp 1", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h1000_0120) begin errors++; $display("FAIL basic_add2: got %h exp 10000120", bus_if.pf_add_o); end
    if (cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt1: got %0d exp 1", cnt); end
    step();
    exp_cnt = 2;
    checks += 3;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL basic_idle_req: got %0b exp 0", bus_if.pf_req_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b exp 0", busy); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL basic_cnt2: got %0d exp %0d", cnt, exp_cnt); end
  endtask

  task automatic test_stalled_grant();
    bus_if.pf_gnt_i = 1'b0;
    pulse_miss(32'h1000_0104);
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %0b exp 1", i, bus_if.pf_req_o); end
      if (bus_if.pf_add_o !== 32'h1000_0110) begin errors++; $display("FAIL stall_add[%0d]: got %h exp 10000110", i, bus_if.pf_add_o); end
      step();
    end
    checks++;
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt_hold: got %0d exp %0d", cnt, exp_cnt); end
    bus_if.pf_gnt_i = 1'b1;
    step();
    checks++;
    if (bus_if.pf_add_o !== 32'h1000_0120) begin errors++; $display("FAIL stall_add2: got %h exp 10000120", bus_if.pf_add_o); end
    step();
    exp_cnt += 2;
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL stall_end_req: got %0b exp 0", bus_if.pf_req_o); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt: got %0d exp %0d", cnt, exp_cnt); end
  endtask

  task automatic test_page_boundary();
    bus_if.pf_gnt_i = 1'b1;
    pulse_miss(32'h0000_0FE8);
    checks += 2;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL page_req: got %0b exp 1", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h0000_0FF0) begin errors++; $display("FAIL page_add: got %h exp 00000ff0", bus_if.pf_add_o); end
    step();
    exp_cnt += 1;
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL page_stop: got %0b exp 0", bus_if.pf_req_o); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL page_cnt: got %0d exp %0d", cnt, exp_cnt); end
    pulse_miss(32'h0000_0FF4);
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL page_last_req: got %0b exp 0", bus_if.pf_req_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL page_last_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_window_pending();
    bus_if.pf_gnt_i = 1'b0;
    pulse_miss(32'h0000_0104);
    pulse_miss(32'h0000_0118);
    pulse_miss(32'h0000_0800);
    checks += 2;
    if (bus_if.pf_add_o !== 32'h0000_0110) begin errors++; $display("FAIL win_add: got %h exp 00000110", bus_if.pf_add_o); end
    if (busy !== 1'b1) begin errors++; $display("FAIL win_busy: got %0b exp 1", busy); end
    bus_if.pf_gnt_i = 1'b1;
    step();
    checks++;
    if (bus_if.pf_add_o !== 32'h0000_0120) begin errors++; $display("FAIL win_add2: got %h exp 00000120", bus_if.pf_add_o); end
    step();
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL pend_gap_req: got %0b exp 0", bus_if.pf_req_o); end
    if (busy !== 1'b1) begin errors++; $display("FAIL pend_gap_busy: got %0b exp 1", busy); end
    step();
    checks += 2;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL pend_req: got %0b exp 1", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h0000_0810) begin errors++; $display("FAIL pend_add1: got %h exp 00000810", bus_if.pf_add_o); end
    step();
    checks++;
    if (bus_if.pf_add_o !== 32'h0000_0820) begin errors++; $display("FAIL pend_add2: got %h exp 00000820", bus_if.pf_add_o); end
    step();
    step();
    exp_cnt += 4;
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL win_drop_req: got %0b exp 0", bus_if.pf_req_o); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL win_cnt: got %0d exp %0d", cnt, exp_cnt); end
  endtask

  task automatic test_enable_drop();
    enable = 1'b1; bus_if.pf_gnt_i = 1'b0;
    pulse_miss(32'h0000_3004);
    enable = 1'b0;
    pulse_miss(32'h0000_5000);
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL en_hold_req[%0d]: got %0b exp 1", i, bus_if.pf_req_o); end
      if (bus_if.pf_add_o !== 32'h0000_3010) begin errors++; $display("FAIL en_hold_add[%0d]: got %h exp 00003010", i, bus_if.pf_add_o); end
      step();
    end
    bus_if.pf_gnt_i = 1'b1;
    step();
    exp_cnt += 1;
    checks += 3;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL en_stop_req: got %0b exp 0", bus_if.pf_req_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL en_stop_busy: got %0b exp 0", busy); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL en_cnt: got %0d exp %0d", cnt, exp_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL en_quiet[%0d]: got %0b exp 0", i, bus_if.pf_req_o); end
    end
    enable = 1'b1; bus_if.pf_gnt_i = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; bus_if.pf_gnt_i = 1'b0;
    pulse_miss(32'h1000_0104);
    checks++;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL ar_pre_req: got %0b exp 1", bus_if.pf_req_o); end
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    checks += 3;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL ar_req: got %0b exp 0", bus_if.pf_req_o); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt: got %0d exp 0", cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %0b exp 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    pulse_miss(32'h0000_2000);
    checks += 2;
    if (bus_if.pf_req_o !== 1'b1) begin errors++; $display("FAIL ar_after_req: got %0b exp 1", bus_if.pf_req_o); end
    if (bus_if.pf_add_o !== 32'h0000_2010) begin errors++; $display("FAIL ar_after_add: got %h exp 00002010", bus_if.pf_add_o); end
    bus_if.pf_gnt_i = 1'b1;
    step();
    step();
    exp_cnt = 2;
    checks += 2;
    if (bus_if.pf_req_o !== 1'b0) begin errors++; $display("FAIL ar_end_req: got %0b exp 0", bus_if.pf_req_o); end
    if (cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL ar_end_cnt: got %0d exp %0d", cnt, exp_cnt); end
  endtask

  // Burst-level reference: a trigger opens a run of PF_DEPTH lines clipped at the page end;
  // the window is the set of lines not yet granted.
  task automatic model_step(input bit en, input bit mv, input logic [31:0] ma, input bit g);
    logic [31:0] ml, ta, f, old_cur;
    int          old_rem;
    bit          fin, inwin, tv;
    ml = ma & ~(32'(L) - 32'd1);
    if (!m_active) begin
      tv = mv | m_pend_v;
      ta = mv ? ml : m_pend_a;
      m_pend_v = 1'b0;
      f = ta + 32'(L);
      if (en && tv && (f / 4096) == (ta / 4096)) begin
        m_active = 1'b1; m_cur = f; m_rem = D;
      end
    end else begin
      fin = 1'b0; old_cur = m_cur; old_rem = m_rem;
      if (g) begin
        if (m_cnt < 65535) m_cnt++;
        m_cur = m_cur + 32'(L);
        m_rem--;
        if (old_rem == 1 || ((old_cur + 32'(L)) / 4096) != (old_cur / 4096) || !en) begin
          m_active = 1'b0; fin = 1'b1;
        end
      end
      if (mv) begin
        inwin = 1'b0;
        for (int k = 0; k < old_rem; k++) if (ml == old_cur + 32'(k * L)) inwin = 1'b1;
        if (fin || !inwin) begin m_pend_v = 1'b1; m_pend_a = ml; end
      end
    end
    if (!en) m_pend_v = 1'b0;
  endtask

  task automatic test_random();
    bit          en, mv, g;
    logic [31:0] ma, pg;
    rst = 1'b1; bus_if.miss_valid_i = 1'b0; bus_if.pf_gnt_i = 1'b0;
    step();
    rst = 1'b0;
    m_active = 1'b0; m_cur = '0; m_rem = 0; m_pend_v = 1'b0; m_pend_a = '0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom % 10) != 0;
      mv = ($urandom % 4) == 0;
      g  = ($urandom % 2) == 1;
      case ($urandom % 3)
        0: pg = 32'h0000_0000;
        1: pg = 32'h0000_1000;
        default: pg = 32'hFFFF_F000;
      endcase
      ma = pg + (($urandom % 2) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(4032, 4095)));
      if (m_active && ($urandom % 3) == 0) ma = m_cur + 32'($urandom_range(0, 47));
      enable = en; bus_if.miss_valid_i = mv; bus_if.miss_addr_i = ma; bus_if.pf_gnt_i = g;
      model_step(en, mv, ma, g);
      step();
      checks += 3;
      if (bus_if.pf_req_o !== m_active) begin errors++; $display("FAIL rnd_req@%0d: got %0b exp %0b", c, bus_if.pf_req_o, m_active); end
      if (busy !== (m_active | m_pend_v)) begin errors++; $display("FAIL rnd_busy@%0d: got %0b exp %0b", c, busy, m_active | m_pend_v); end
      if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d exp %0d", c, cnt, m_cnt); end
      if (m_active) begin
        checks++;
        if (bus_if.pf_add_o !== m_cur) begin errors++; $display("FAIL rnd_add@%0d: got %h exp %h", c, bus_if.pf_add_o, m_cur); end
      end
    end
    bus_if.miss_valid_i = 1'b0; bus_if.pf_gnt_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_stalled_grant();
    test_page_boundary();
    test_window_pending();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
